// File: rtl/power_pkg.sv
// Shared widths and output FSM encoding for the power-stage result serializer.
package power_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_e;
endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding whole results; head is read combinationally from the read pointer.
// Storage is not reset, only pointers and occupancy count are.
module result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/result_serializer.sv
// Buffers double-width results and emits each as low word then high word (o_last on high).
// Upstream cannot be stalled: a result arriving to a full buffer with no pop is dropped and flagged.
module result_serializer
    import power_pkg::*;
#(
    parameter int DATA_WIDTH = power_pkg::DATA_WIDTH,
    parameter int DEPTH      = power_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_valid,
    input  logic [2*DATA_WIDTH-1:0]    i_data,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic                       o_last,
    output logic                       o_overflow,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int CW = $clog2(DEPTH+1);

    state_e                    state_q, state_d;
    logic                      overflow_q, overflow_d;
    logic                      push, pop;
    logic                      full, empty;
    logic [CW-1:0]             count;
    logic [2*DATA_WIDTH-1:0]   head;

    // A full buffer still accepts a result when the head leaves in the same cycle.
    assign pop  = (state_q == SEND_HI) && i_ready;
    assign push = i_valid && (!full || pop);

    result_fifo #(
        .WIDTH (2*DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (i_data),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q | (i_valid && full && !pop);
        o_valid    = 1'b0;
        o_data     = '0;
        o_last     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = SEND_LO;
            end
            SEND_LO: begin
                o_valid = 1'b1;
                o_data  = head[DATA_WIDTH-1:0];
                if (i_ready) state_d = SEND_HI;
            end
            SEND_HI: begin
                o_valid = 1'b1;
                o_data  = head[2*DATA_WIDTH-1:DATA_WIDTH];
                o_last  = 1'b1;
                if (i_ready) state_d = ((count > CW'(1)) || push) ? SEND_LO : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;
    assign o_count    = count;
endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench: a result-level model predicts the word stream, occupancy, overflow and output validity.
module tb_result_serializer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } word_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_valid = 1'b0;
    logic [2*DW-1:0]   i_data = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DW-1:0]     o_data;
    logic              o_last;
    logic              o_overflow;
    logic [CW-1:0]     o_count;

    result_serializer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .o_last     (o_last),
        .o_overflow (o_overflow),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_fail = 0;
    word_t exp_q[$];
    int    m_count = 0;
    logic  m_ovf = 1'b0;
    logic  exp_valid = 1'b0;
    logic  known = 1'b0;
    logic  post_rst = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: results occupy the buffer until their high word is accepted; an idle
    // output wakes one cycle after a push, a busy output keeps streaming.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            m_count   = 0;
            m_ovf     = 1'b0;
            exp_valid = 1'b0;
            post_rst  = 1'b1;
            known     = 1'b1;
        end else if (known) begin
            logic  accepted;
            logic  was_valid;
            word_t w;
            chk("o_count", 64'(o_count), 64'(m_count));
            chk("o_overflow", 64'(o_overflow), 64'(m_ovf));
            chk("o_valid", 64'(o_valid), 64'(exp_valid));
            if (post_rst) begin
                chk("o_data_after_reset", 64'(o_data), 64'd0);
                chk("o_last_after_reset", 64'(o_last), 64'd0);
                post_rst = 1'b0;
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("word_unexpected", 64'(o_data), 64'hdead);
                end else begin
                    chk("o_data", 64'(o_data), 64'(exp_q[0].d));
                    chk("o_last", 64'(o_last), 64'(exp_q[0].l));
                    if (i_ready) begin
                        w = exp_q.pop_front();
                        if (w.l) m_count--;
                    end
                end
            end
            was_valid = exp_valid;
            exp_valid = (exp_q.size() > 0);
            accepted  = 1'b0;
            if (i_valid) begin
                if (m_count < DEPTH) begin
                    exp_q.push_back('{d: i_data[DW-1:0],    l: 1'b0});
                    exp_q.push_back('{d: i_data[2*DW-1:DW], l: 1'b1});
                    m_count++;
                    accepted = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (accepted && was_valid) exp_valid = 1'b1;
        end
    end

    task automatic cyc(input logic v, input logic [2*DW-1:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_ready = 1'b0;
        i_valid = 1'b0;
        reset   = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_count != 0 || o_valid) && k < 200) begin
            cyc(1'b0, '0, 1'b1);
            k++;
        end
        cyc(1'b0, '0, 1'b1);
        chk(name, 64'(k < 200), 64'd1);
    endtask

    initial begin
        do_reset();
        cyc(1'b0, '0, 1'b1);
        chk("reset_count", 64'(o_count), 64'd0);

        // single result
        cyc(1'b1, 64'h0000_0019_0000_0004, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("single_lo", {31'd0, o_last, o_data}, {31'd0, 1'b0, 32'h4});
        cyc(1'b0, '0, 1'b1);
        chk("single_hi", {31'd0, o_last, o_data}, {31'd0, 1'b1, 32'h19});
        drain("drain_single");

        // backpressure in SEND_LO
        cyc(1'b1, 64'h1111_2222_3333_4444, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0);
        drain("drain_backpressure");

        // fill past capacity
        for (int i = 1; i <= 5; i++) cyc(1'b1, 64'(i), 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0);
        chk("fill_overflow", 64'(o_overflow), 64'd1);
        drain("drain_fill");

        // full plus push coinciding with the high-word pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1);
        cyc(1'b0, '0, 1'b0);
        chk("full_pushpop_count", 64'(o_count), 64'(DEPTH));
        drain("drain_full_pushpop");

        // wrap: ten results paced at the output word rate
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, {$urandom, $urandom}, 1'b1);
            cyc(1'b0, '0, 1'b1);
        end
        drain("drain_wrap");

        // reset while sending a high word with three results buffered
        for (int i = 0; i < 3; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("pre_reset_last", 64'(o_last), 64'd1);
        do_reset();
        cyc(1'b1, 64'h0000_0077_0000_0066, 1'b1);
        drain("drain_after_reset");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 99) < 35, {$urandom, $urandom}, $urandom_range(0, 99) < 70);
        end
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
